keypad_scanner: RTL
===================

# keypad_scanner

Scans a 4x4 passive key matrix: drives one row low at a time, samples the four column inputs, debounces whole-matrix snapshots, and reports single key presses as a 4-bit code with a one-cycle valid strobe. It is the input-side counterpart to the dot-matrix display driver: the same row-strobe scanning scheme, but reading the matrix instead of lighting it. It feeds the game FSM, for example as the defuse-code entry path, alongside the existing start button.

## Interface
- SCAN_CNT, 50000, clock cycles per row slot (1 ms at 50 MHz); legal range 4 to 131071.
- DEBOUNCE_FRAMES, 4, consecutive identical full-matrix frames required before a new state is accepted; legal range 1 to 15.

- i_Clk  in  1  system clock, 50 MHz.
- i_Rst  in  1  asynchronous, active-low reset.
- i_Key_Col  in  4  column sense lines, active-low, externally pulled up, asynchronous to i_Clk.
- o_Key_Row  out  4  row drive, active-low one-cold; bit r low means row r is strobed.
- o_Key_Code  out  4  code of the last accepted key, {row[1:0], col[1:0]}; held until the next accepted key.
- o_fKey_Valid  out  1  one-cycle pulse when o_Key_Code is updated.
- o_fKey_Held  out  1  level; high while the debounced state contains at least one pressed key.

## Operation
- **Synchroniser:** i_Key_Col passes through a 2-flop synchroniser; only the synchronised value is used.
- **Slot counter:** 17-bit counter runs 0 to SCAN_CNT-1, then wraps to 0. Tick = (count == SCAN_CNT-1).
- **Row rotation:** on each tick, o_Key_Row rotates left by one: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- **Sampling:** on each tick, the inverted synchronised columns are written to frame bits [4r+3:4r], where r is the row currently strobed. A 1 in the frame means pressed. Sampling uses the row value from before the rotation.
- **Frame end:** the tick with row 3 strobed. At that tick, the completed frame (including the row-3 bits sampled in that same cycle) is compared with the previous frame register, and then copied into it.
  - Mismatch: stable count is cleared to 0.
  - Match: stable count increments, saturating at DEBOUNCE_FRAMES.
  - When stable count transitions to DEBOUNCE_FRAMES, the frame is loaded into the debounced register.
- **Derived signals from the debounced register:** none (all zero), single (exactly one bit set), multi (two or more bits set). o_fKey_Held = !none, registered.
- **FSM:** evaluates on the cycle after each debounced-register update.
  - IDLE:
    - single -> load o_Key_Code with the index of the set bit, pulse o_fKey_Valid, go to PRESS.
    - multi -> go to WAIT_REL.
    - none -> stay in IDLE.
  - PRESS:
    - none -> IDLE.
    - multi, or a different single key -> WAIT_REL, with no pulse.
  - WAIT_REL:
    - none -> IDLE.
    - anything else -> stay in WAIT_REL.
- **Ghost keys and rollover:** multi-key states never produce a code. After any multi-key state, all keys must be released before the next code is accepted.

## Timing
- **Reset values:**
  - o_Key_Row = 4'b1110, o_Key_Code = 0, o_fKey_Valid = 0, o_fKey_Held = 0.
  - Slot counter 0, synchroniser 1111; frame, previous-frame and debounced registers all zero; stable count 0; FSM in IDLE.
- **Frame period:** 4*SCAN_CNT cycles.
- **Press latency:** a key first appears in frame k. The debounced register updates at the end of frame k+DEBOUNCE_FRAMES. o_fKey_Valid pulses one cycle later, and o_fKey_Held rises on that same cycle.
- **Release latency:** release first appears in frame k. The debounced register clears at the end of frame k+DEBOUNCE_FRAMES, and o_fKey_Held falls one cycle later.
- **Chatter:** any frame that differs from its predecessor restarts the count. A press or release that bounces inside every frame is never accepted.
- **Reset mid-operation:** all state returns to its reset value. A key held across reset is re-debounced from frame 0 and produces a fresh pulse.
- **Fixed cycle positions:** o_fKey_Valid is never asserted on two consecutive cycles. Column settle time after a row change is SCAN_CNT-3 cycles minimum before sampling.

## Test plan
Benches use SCAN_CNT=4, DEBOUNCE_FRAMES=2, so a frame is 16 cycles.
- **Reset and rotation:** release reset -> o_Key_Row = 1110 and all outputs 0; rows rotate every 4 cycles and return to 1110 after 16 cycles.
- **Single press:** a matrix model pulls column 1 low whenever row 2 is strobed, held from frame 0 -> exactly one o_fKey_Valid pulse, with o_Key_Code = 9, at the cycle after the end of frame 2. o_fKey_Held rises on the same cycle and falls 3 frames plus 1 cycle after release.
- **Bounce:** key toggles every 5 cycles for 6 frames, then holds steady -> no pulse during the toggling; one pulse with the correct code after 3 stable frames.
- **Multi-key and rollover:** press key 0; add key 15; release key 0 while holding 15 -> a single pulse with code 0 only; no code 15 until full release and a fresh press of 15, which gives a pulse with code 15.
- **Reset mid-hold:** key 5 is held and accepted; assert reset for 3 cycles, keeping the key held -> outputs clear; a second pulse with code 5 arrives 3 frames plus 1 cycle after reset release.
- **Repeat press:** press and release key 3 twice, each phase 4 frames long -> two pulses with code 3; o_Key_Code stays 3 in between.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: strobes one row low per slot, debounces whole-matrix frames and
// reports single key presses as {row, col} with a one-cycle valid strobe.
module keypad_scanner #(
  parameter int unsigned SCAN_CNT        = 50000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Key_Col,
  output logic [3:0] o_Key_Row,
  output logic [3:0] o_Key_Code,
  output logic       o_fKey_Valid,
  output logic       o_fKey_Held
);

  localparam logic [16:0] CntMax    = 17'(SCAN_CNT - 1);
  localparam logic [3:0]  StableMax = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {StIdle, StPress, StWaitRel} state_e;

  logic [3:0]  col_meta, col_sync;
  logic [16:0] slot_cnt;
  logic [1:0]  row_idx;
  logic [15:0] frame, prev_frame, deb, frame_done;
  logic [3:0]  stable_cnt;
  logic        deb_upd;
  logic        tick, frame_end;
  logic [4:0]  key_count;
  logic [3:0]  key_idx;
  logic        key_none, key_single, key_multi;
  state_e      state;

  assign tick      = (slot_cnt == CntMax);
  assign frame_end = tick && (row_idx == 2'd3);

  always_comb begin
    row_idx = 2'd0;
    unique case (o_Key_Row)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  // Current frame with the row being sampled this cycle already merged in.
  always_comb begin
    frame_done = frame;
    frame_done[{row_idx, 2'b00} +: 4] = ~col_sync;
  end

  always_comb begin
    key_count = 5'd0;
    key_idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (deb[i]) begin
        key_count = key_count + 5'd1;
        key_idx   = 4'(i);
      end
    end
  end

  assign key_none   = (key_count == 5'd0);
  assign key_single = (key_count == 5'd1);
  assign key_multi  = (key_count > 5'd1);

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      col_meta   <= 4'hF;
      col_sync   <= 4'hF;
      slot_cnt   <= 17'd0;
      o_Key_Row  <= 4'b1110;
      frame      <= 16'h0;
      prev_frame <= 16'h0;
      deb        <= 16'h0;
      stable_cnt <= 4'd0;
      deb_upd    <= 1'b0;
    end else begin
      col_meta <= i_Key_Col;
      col_sync <= col_meta;
      deb_upd  <= 1'b0;
      slot_cnt <= tick ? 17'd0 : slot_cnt + 17'd1;
      if (tick) begin
        o_Key_Row <= {o_Key_Row[2:0], o_Key_Row[3]};
        frame     <= frame_done;
      end
      if (frame_end) begin
        prev_frame <= frame_done;
        if (frame_done != prev_frame) begin
          stable_cnt <= 4'd0;
        end else if (stable_cnt < StableMax) begin
          stable_cnt <= stable_cnt + 4'd1;
          if (stable_cnt == StableMax - 4'd1) begin
            deb     <= frame_done;
            deb_upd <= 1'b1;
          end
        end
      end
    end
  end

  // Multi-key states lock out codes until the whole matrix is released.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state        <= StIdle;
      o_Key_Code   <= 4'd0;
      o_fKey_Valid <= 1'b0;
      o_fKey_Held  <= 1'b0;
    end else begin
      o_fKey_Valid <= 1'b0;
      o_fKey_Held  <= !key_none;
      if (deb_upd) begin
        unique case (state)
          StIdle: begin
            if (key_single) begin
              o_Key_Code   <= key_idx;
              o_fKey_Valid <= 1'b1;
              state        <= StPress;
            end else if (key_multi) begin
              state <= StWaitRel;
            end
          end
          StPress: begin
            if (key_none) state <= StIdle;
            else if (key_multi || key_idx != o_Key_Code) state <= StWaitRel;
          end
          StWaitRel: begin
            if (key_none) state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
